seq_borrow_sub: RTL and testbench

SEQ_BORROW_SUB -- requirements
Module: seq_borrow_sub

---
 rtl/seq_borrow_sub_if.sv | 32 +++
 rtl/seq_borrow_sub.sv | 120 ++++++++++++
 tb/tb_seq_borrow_sub.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_borrow_sub_if.sv
`default_nettype none
// =============================================================================
// Module  : seq_borrow_sub_if
// Brief   : Operand/result handshake bundle for the sequential subtractor.
// Revision: 1.0
// =============================================================================
interface seq_borrow_sub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, d, bout, zero, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, d, bout, zero, ovf
  );
endinterface
`default_nettype wire

// File: rtl/seq_borrow_sub.sv
`default_nettype none
// =============================================================================
// Module  : seq_borrow_sub
// Brief   : Multi-cycle subtractor, SLICE bits per clock with a registered borrow.
// Revision: 1.0
// =============================================================================
module seq_borrow_sub #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input wire              clk,
  input wire              rst_n,
  seq_borrow_sub_if.slave bus
);

  localparam int               c_N    = WIDTH / SLICE;
  localparam int               c_CW   = (c_N > 1) ? $clog2(c_N) : 1;
  localparam logic [c_CW-1:0]  c_LAST = c_CW'(c_N - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic             w_in_ready;
  logic             w_out_valid;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_dw;
  logic             r_amsb;
  logic             r_bmsb;
  logic             r_borrow;
  logic [c_CW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;
  logic             r_zero;
  logic             r_ovf;

  logic                   w_last;
  logic [SLICE:0]         w_sub;
  logic [WIDTH+SLICE-1:0] w_cat;
  logic [WIDTH-1:0]       w_dw_next;

  // Operands shift right one slice per cycle, so the active slice is always the low bits.
  assign w_last    = (r_cnt == c_LAST);
  assign w_sub     = {1'b0, r_a[SLICE-1:0]} - {1'b0, r_b[SLICE-1:0]} - (SLICE+1)'(r_borrow);
  assign w_cat     = {w_sub[SLICE-1:0], r_dw};
  assign w_dw_next = WIDTH'(w_cat >> SLICE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:  if (bus.in_valid)  w_next_state = c_RUN;
      c_RUN:   if (w_last)        w_next_state = c_DONE;
      c_DONE:  if (bus.out_ready) w_next_state = c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready  = (r_state == c_IDLE);
    w_out_valid = (r_state == c_DONE);
  end

  // Result registers only change when the final slice lands, so d stays stable across RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_dw     <= '0;
      r_amsb   <= 1'b0;
      r_bmsb   <= 1'b0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_d      <= '0;
      r_bout   <= 1'b0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_in_ready && bus.in_valid) begin
      r_a      <= bus.a;
      r_b      <= bus.b;
      r_amsb   <= bus.a[WIDTH-1];
      r_bmsb   <= bus.b[WIDTH-1];
      r_borrow <= bus.bin;
      r_cnt    <= '0;
    end else if (r_state == c_RUN) begin
      r_a      <= r_a >> SLICE;
      r_b      <= r_b >> SLICE;
      r_dw     <= w_dw_next;
      r_borrow <= w_sub[SLICE];
      if (w_last) begin
        r_d    <= w_dw_next;
        r_bout <= w_sub[SLICE];
        r_zero <= (w_dw_next == '0);
        r_ovf  <= (r_amsb != r_bmsb) && (w_dw_next[WIDTH-1] != r_amsb);
      end else begin
        r_cnt  <= r_cnt + c_CW'(1);
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.d         = r_d;
  assign bus.bout      = r_bout;
  assign bus.zero      = r_zero;
  assign bus.ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_seq_borrow_sub.sv
`default_nettype none
// =============================================================================
// Module  : tb_seq_borrow_sub
// Brief   : Bench for seq_borrow_sub at SLICE = 4, 1 and 16 (WIDTH = 16).
// Revision: 1.0
// =============================================================================
module tb_seq_borrow_sub;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        iv      [3];
  logic [15:0] ia      [3];
  logic [15:0] ib      [3];
  logic        ibin    [3];
  logic        ordy_in [3];
  logic        ordy    [3];
  logic        ovld    [3];
  logic [15:0] od      [3];
  logic        obout   [3];
  logic        ozero   [3];
  logic        oovf    [3];

  logic [18:0] prev_r  [3];
  int          lat     [3] = '{4, 16, 1};

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int SL = (g == 0) ? 4 : ((g == 1) ? 1 : 16);
    seq_borrow_sub_if #(.WIDTH(16)) bus ();
    assign bus.in_valid  = iv[g];
    assign bus.a         = ia[g];
    assign bus.b         = ib[g];
    assign bus.bin       = ibin[g];
    assign bus.out_ready = ordy_in[g];
    assign ordy[g]       = bus.in_ready;
    assign ovld[g]       = bus.out_valid;
    assign od[g]         = bus.d;
    assign obout[g]      = bus.bout;
    assign ozero[g]      = bus.zero;
    assign oovf[g]       = bus.ovf;
    seq_borrow_sub #(.WIDTH(16), .SLICE(SL)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] d;
    logic        bout;
    logic        zero;
    logic        ovf;
  } vec_t;

  vec_t tbl [8];

  // Reference: plain integer arithmetic, signed overflow judged by range.
  function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y, input logic c);
    int          u;
    int          s;
    logic [15:0] dd;
    u  = int'(x) - int'(y) - int'(c);
    s  = int'($signed(x)) - int'($signed(y)) - int'(c);
    dd = u[15:0];
    return {dd, (u < 0), (dd == 16'h0000), ((s < -32768) || (s > 32767))};
  endfunction

  function automatic logic [18:0] out_rec(input int k);
    return {od[k], obout[k], ozero[k], oovf[k]};
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=0x%0h required=0x%0h", nm, k, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in DONE with out_ready low.
  task automatic do_op(input int k, input logic [15:0] va, input logic [15:0] vb, input logic vbin,
                       input logic [18:0] exp);
    int n;
    iv[k]   = 1'b1;
    ia[k]   = va;
    ib[k]   = vb;
    ibin[k] = vbin;
    n = 0;
    while (ordy[k] !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("accept_ready", k, ordy[k], 1);
    tick();
    iv[k] = 1'b0;
    chk("run_busy", k, {ordy[k], ovld[k]}, 2'b00);
    chk("run_hold_prev", k, out_rec(k), prev_r[k]);
    n = 0;
    while (ovld[k] !== 1'b1 && n < 40) begin
      ia[k]   = ~ia[k];
      ib[k]   = 16'($urandom);
      ibin[k] = ~ibin[k];
      tick();
      n++;
    end
    chk("latency", k, n, lat[k]);
    chk("d", k, od[k], exp[18:3]);
    chk("bout_zero_ovf", k, {obout[k], ozero[k], oovf[k]}, exp[2:0]);
    prev_r[k] = exp;
  endtask

  task automatic hold(input int k, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick();
      chk("bp_stable", k, out_rec(k), prev_r[k]);
      chk("bp_busy", k, {ordy[k], ovld[k]}, 2'b01);
    end
  endtask

  task automatic handshake(input int k);
    ordy_in[k] = 1'b1;
    tick();
    ordy_in[k] = 1'b0;
    chk("back_to_idle", k, {ordy[k], ovld[k]}, 2'b10);
    chk("idle_hold_result", k, out_rec(k), prev_r[k]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] va;
    logic [15:0] vb;
    logic        vbin;

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; ia[k] = '0; ib[k] = '0; ibin[k] = 1'b0; ordy_in[k] = 1'b0;
      prev_r[k] = '0;
    end

    tbl[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{16'h5555, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{16'hFFFF, 16'h0001, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{16'h0001, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0};

    #12;
    for (int k = 0; k < 3; k++) begin
      chk("reset_handshake", k, {ordy[k], ovld[k]}, 2'b10);
      chk("reset_outputs", k, out_rec(k), 0);
    end
    tick();
    rst_n = 1'b1;

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++) begin
        do_op(k, tbl[i].a, tbl[i].b, tbl[i].bin,
              {tbl[i].d, tbl[i].bout, tbl[i].zero, tbl[i].ovf});
        hold(k, i % 3);
        handshake(k);
      end
    end

    // Back-pressure with new operands already waiting on in_valid.
    do_op(0, 16'h1234, 16'h0234, 1'b0, model(16'h1234, 16'h0234, 1'b0));
    iv[0] = 1'b1; ia[0] = 16'h0000; ib[0] = 16'h0001; ibin[0] = 1'b0;
    hold(0, 3);
    handshake(0);
    do_op(0, 16'h0000, 16'h0001, 1'b0, model(16'h0000, 16'h0001, 1'b0));
    handshake(0);

    // Reset two slices into a run.
    iv[0] = 1'b1; ia[0] = 16'hAAAA; ib[0] = 16'h1111; ibin[0] = 1'b0;
    tick();
    iv[0] = 1'b0;
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("async_reset_handshake", k, {ordy[k], ovld[k]}, 2'b10);
      chk("async_reset_outputs", k, out_rec(k), 0);
      prev_r[k] = '0;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("no_aborted_result", 0, {ordy[0], ovld[0]}, 2'b10);
    end
    do_op(0, 16'hFFFF, 16'h0001, 1'b0, {16'hFFFE, 1'b0, 1'b0, 1'b0});
    handshake(0);

    // Reset while holding a result in DONE.
    do_op(2, 16'h0003, 16'h0005, 1'b0, model(16'h0003, 16'h0005, 1'b0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_in_done", 2, {ordy[2], ovld[2], out_rec(2)}, {2'b10, 19'h0});
    prev_r[0] = '0; prev_r[1] = '0; prev_r[2] = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 25; i++) begin
        va   = 16'($urandom);
        vb   = 16'($urandom);
        vbin = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 4) == 0) vb = va;
        repeat ($urandom_range(0, 2)) tick();
        do_op(k, va, vb, vbin, model(va, vb, vbin));
        hold(k, int'($urandom_range(0, 3)));
        handshake(k);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
